// File: rtl/multibyte_add_sequencer_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer:
// FSM state encodings, byte width and index-width helper.
package multibyte_add_sequencer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte index counter width; a single-byte operand still needs one bit.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/eight_bit_full_adder.sv
// Combinational 8-bit ripple-carry adder shared by the sequencer, one byte
// per clock.
module eight_bit_full_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       carry
);

    logic [8:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        carry = c[8];
    end

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Adds or subtracts two NBYTES-wide operands through one shared 8-bit adder,
// LSB byte first, chaining the carry between bytes.
module multibyte_add_sequencer
    import multibyte_add_sequencer_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       sub,
    input  logic                       cin,
    input  logic [BYTE_W*NBYTES-1:0]   a,
    input  logic [BYTE_W*NBYTES-1:0]   b,
    output logic                       busy,
    output logic                       done,
    output logic [BYTE_W*NBYTES-1:0]   result,
    output logic                       cout
);

    localparam int             W        = BYTE_W * NBYTES;
    localparam int             IW       = idx_width(NBYTES);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NBYTES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [W-1:0]          opa;
    logic [W-1:0]          opb;
    logic [IW-1:0]         idx;
    logic                  carry;
    logic                  accept;
    logic                  last;
    logic [BYTE_W-1:0]     add_x;
    logic [BYTE_W-1:0]     add_y;
    logic [BYTE_W-1:0]     add_sum;
    logic                  add_carry;

    // A new request is taken in IDLE and also in DONE, giving back-to-back operation.
    assign accept = start && (state != ST_RUN);
    assign last   = (idx == LAST_IDX);
    assign add_x  = opa[BYTE_W*idx +: BYTE_W];
    assign add_y  = opb[BYTE_W*idx +: BYTE_W];

    eight_bit_full_adder u_adder (
        .x     (add_x),
        .y     (add_y),
        .cin   (carry),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = accept ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1, so b is inverted at latch time and the carry seeded with 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            opa    <= '0;
            opb    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            opa    <= a;
            opb    <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : cin;
            idx    <= '0;
            result <= '0;
        end else if (state == ST_RUN) begin
            result[BYTE_W*idx +: BYTE_W] <= add_sum;
            carry                        <= add_carry;
            if (last) begin
                idx  <= '0;
                cout <= add_carry;
            end else begin
                idx  <= idx + 1'b1;
            end
        end
    end

endmodule
